// File: rtl/led_pattern_engine.sv
// LED pattern generator: prescaled stepping through Johnson, ring, bounce or
// binary-count patterns, with preload, direction control and step/wrap pulses.
module led_pattern_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 25000000,
    parameter int unsigned CW    = $clog2(DIV) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    localparam int unsigned CNTW = WIDTH + 1;

    localparam logic [CW-1:0]    PRESC_LAST = CW'(DIV - 1);
    localparam logic [WIDTH-1:0] MSB_ONE    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONE    = WIDTH'(1);

    localparam logic [CNTW-1:0] LAST_JOHNSON = CNTW'(2 * WIDTH - 1);
    localparam logic [CNTW-1:0] LAST_RING    = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] LAST_BOUNCE  = CNTW'(2 * WIDTH - 3);
    localparam logic [CNTW-1:0] LAST_COUNT   = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'b00,
        MODE_RING    = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_COUNT   = 2'b11
    } mode_e;

    logic [CW-1:0]    presc_r,  presc_nxt;
    logic [CNTW-1:0]  cnt_r,    cnt_nxt;
    logic             flag_r,   flag_nxt;
    mode_e            mode_r,   mode_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             tick_nxt, wrap_nxt;

    logic             step_due_c;
    logic             mode_chg_c;
    logic             one_hot_c;
    logic [WIDTH-1:0] seed_c;
    logic [WIDTH-1:0] pat_c;
    logic             seeded_c;
    logic             flag_step_c;
    logic [CNTW-1:0]  last_idx_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_r <= '0;
            cnt_r   <= '0;
            flag_r  <= 1'b0;
            mode_r  <= MODE_JOHNSON;
            q       <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            presc_r <= presc_nxt;
            cnt_r   <= cnt_nxt;
            flag_r  <= flag_nxt;
            mode_r  <= mode_nxt;
            q       <= q_nxt;
            tick    <= tick_nxt;
            wrap    <= wrap_nxt;
        end
    end

    // Step qualifiers
    always_comb begin
        step_due_c = en && (presc_r == PRESC_LAST);
        mode_chg_c = (mode_e'(mode) != mode_r);
        one_hot_c  = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
        seed_c     = dir ? LSB_ONE : MSB_ONE;
    end

    // Candidate pattern for a step in the registered mode
    always_comb begin
        pat_c       = q;
        seeded_c    = 1'b0;
        flag_step_c = flag_r;
        last_idx_c  = LAST_JOHNSON;
        case (mode_r)
            MODE_JOHNSON: begin
                pat_c      = dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
                last_idx_c = LAST_JOHNSON;
            end
            MODE_RING: begin
                last_idx_c = LAST_RING;
                if (q == '0) begin
                    pat_c    = seed_c;
                    seeded_c = 1'b1;
                end else begin
                    pat_c = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
                end
            end
            MODE_BOUNCE: begin
                last_idx_c = LAST_BOUNCE;
                if (!one_hot_c) begin
                    pat_c       = seed_c;
                    seeded_c    = 1'b1;
                    flag_step_c = 1'b0;
                end else begin
                    pat_c = (dir ^ flag_r) ? (q << 1) : (q >> 1);
                    // Reaching either end flips travel for the following step
                    if (pat_c[0] || pat_c[WIDTH-1]) begin
                        flag_step_c = ~flag_r;
                    end
                end
            end
            MODE_COUNT: begin
                pat_c      = dir ? (q - WIDTH'(1)) : (q + WIDTH'(1));
                last_idx_c = LAST_COUNT;
            end
        endcase
    end

    // Next state: load > mode change > step > idle
    always_comb begin
        presc_nxt = presc_r;
        cnt_nxt   = cnt_r;
        flag_nxt  = flag_r;
        mode_nxt  = mode_r;
        q_nxt     = q;
        tick_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (load) begin
            q_nxt     = load_val;
            presc_nxt = '0;
            cnt_nxt   = '0;
        end else if (mode_chg_c) begin
            mode_nxt  = mode_e'(mode);
            presc_nxt = '0;
            cnt_nxt   = '0;
        end else if (en) begin
            if (step_due_c) begin
                presc_nxt = '0;
                q_nxt     = pat_c;
                flag_nxt  = flag_step_c;
                tick_nxt  = 1'b1;
                if (seeded_c) begin
                    cnt_nxt = '0;
                end else if (cnt_r == last_idx_c) begin
                    cnt_nxt  = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNTW'(1);
                end
            end else begin
                presc_nxt = presc_r + CW'(1);
            end
        end
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised LED pattern generator; successor to the fixed 8-bit Johnson chaser.
- Contains an internal prescaler, a WIDTH-bit pattern register and four run-time selectable modes: Johnson, ring, bounce and binary count.
- Supports selectable direction, enable/pause, synchronous preload and step/wrap status pulses.
- Sits between the board clock and the LED bank; `q` drives the LEDs directly.

Parameters:
- WIDTH, 8, pattern/LED width in bits; must be ≥ 2.
- DIV, 25000000, clk cycles per pattern step; must be ≥ 1.
- CW, $clog2(DIV)+1, prescaler counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- en  input  1  1 = run; 0 = pause (prescaler and pattern frozen).
- mode  input  2  pattern select: 00 Johnson, 01 ring, 10 bounce, 11 binary count.
- dir  input  1  0 = shift toward LSB / count up; 1 = shift toward MSB / count down.
- load  input  1  synchronous preload strobe.
- load_val  input  WIDTH  value written to `q` on `load`.
- q  output  WIDTH  current pattern (registered).
- tick  output  1  one-cycle pulse, high in the cycle after each step edge.
- wrap  output  1  one-cycle pulse, coincident with `tick`, when the pattern completes a full cycle.

Behaviour:
- **Reset (reset=0, async):**
  - q=0, tick=0, wrap=0.
  - Prescaler=0, step counter=0, bounce direction flag=0, registered mode copy=00.
- **Priority per edge:** load > mode change > step > idle.
- **Prescaler:**
  - Increments while en=1.
  - On the edge where prescaler==DIV-1 and en=1: prescaler←0 and a step is executed.
  - DIV=1 gives a step every clock.
  - en=0 holds the prescaler and q; tick=0.
- **tick/wrap:**
  - Registered outputs, so they are high exactly one cycle, aligned with the new q value.
  - Both are 0 in every other cycle.
- **Load:**
  - On load=1: q←load_val, prescaler←0, step counter←0, no tick, no wrap.
  - Load is honoured even when en=0.
- **Mode change:**
  - When mode differs from its registered copy: copy updates, step counter←0, prescaler←0, q unchanged, no step that edge.
  - The new mode applies from the next tick.
- **Step, Johnson (00):**
  - dir=0: q←{~q[0], q[WIDTH-1:1]}.
  - dir=1: q←{q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Period 2·WIDTH steps.
- **Step, ring (01):**
  - Rotate (dir=0 toward LSB, dir=1 toward MSB). Period WIDTH.
  - If q==0 at a step: q←seed, where seed = MSB one-hot for dir=0 and LSB one-hot for dir=1; step counter←0.
- **Step, bounce (10):**
  - Single lit bit moves in direction (dir XOR flag).
  - The flag toggles on the step that reaches bit 0 or bit WIDTH-1, so the next step reverses.
  - Period 2·(WIDTH-1).
  - If q is not one-hot at a step: q←seed (as for ring), flag←0, step counter←0.
- **Step, count (11):**
  - q←q+1 (dir=0) or q−1 (dir=1), modulo 2^WIDTH. Period 2^WIDTH.
- **Step counter:**
  - Counts steps within the current mode, width ≥ WIDTH+1 bits.
  - wrap=1 on the step where the counter reaches period−1; the counter then returns to 0.
  - A seed load counts as step 0 with no wrap.
- **Direction change mid-pattern:** takes effect on the next step; the step counter is not cleared.
- **Reset mid-step:** dominates all inputs; no partial update survives.

Test Plan:
- WIDTH=8, DIV=4, reset released, en=1, mode=00, dir=0 → steps every 4 clks:
  - q = 80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00.
  - wrap high only with the 16th value (00); tick high 16 times.
- Ring, dir=1, from q=0 → first step q=01 (seed, no wrap), then 02,04,…,80,01; wrap with each return to 01 after 8 steps.
- Bounce, load_val=80, dir=0 → 40,20,10,08,04,02,01,02,…,80; wrap on 80 after 14 steps. Then load_val=0x81 followed by a step → q=80 (seed).
- Count, dir=1, load_val=00 → next step FF, then FE. Set en=0 for 20 clks → q, prescaler and tick frozen; resume → next step after the remaining prescaler cycles.
- Simultaneous load=1 and step edge → q=load_val, no tick. Mode change on a tick edge → q unchanged, no tick, new mode applies 4 clks later.
- Assert reset=0 asynchronously mid-prescale, between clk edges → q=0, tick=0, wrap=0 immediately. After release, the first step occurs DIV clks later.
